lb_cnt_bank: RTL

Parametrised multi-channel counter bank with LocalBus control, debounced push-button pause/clear, LED display and a logic-analyzer event bus. It generalises the single free-running LED counter to NUM_CH independent up/down counters. Each counter is loadable, maskable and overflow-flagged, and is visible through the FTDI-bridged LocalBus. The block sits beside the UART-to-LocalBus bridge and the Sump3 core, feeding the core's `sumpd_events` input.

---
 rtl/lb_cnt_bank_pkg.sv | 16 +
 rtl/btn_debounce.sv | 41 ++++
 rtl/lb_cnt_bank.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/lb_cnt_bank_pkg.sv
// Shared encodings for the LocalBus counter bank: channel FSM states and register offsets.
package lb_cnt_bank_pkg;

  typedef enum logic [1:0] {
    StReset    = 2'd0,
    StPause    = 2'd1,
    StCount    = 2'd2,
    StDisabled = 2'd3
  } ch_state_e;

  localparam logic [7:0] RegCtrl   = 8'h00;
  localparam logic [7:0] RegStatus = 8'h04;
  localparam logic [7:0] RegCount0 = 8'h08;
  localparam logic [7:0] RegStride = 8'h04;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output follows the input only
// after it has held a new level for DB_CYC consecutive clocks.
module btn_debounce #(
  parameter int unsigned DB_CYC = 1000000
) (
  input  logic clk_lb,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CntW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            dout_q;

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      if (DB_CYC == 0) begin
        dout_q <= sync_q[1];
        cnt_q  <= '0;
      end else if (sync_q[1] == dout_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DB_CYC - 1)) begin
        dout_q <= sync_q[1];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/lb_cnt_bank.sv
// Bank of NUM_CH up/down counters with LocalBus registers, debounced pause/clear buttons,
// an LED view of the selected counter and a Sump3 event vector.
module lb_cnt_bank
  import lb_cnt_bank_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned LED_W     = 8,
  parameter int unsigned DB_CYC    = 1000000,
  parameter logic [7:0]  BASE_ADDR = 8'hA0
) (
  input  logic             clk_lb,
  input  logic             reset_n,
  input  logic             btn_reset,
  input  logic             btn_pause,
  input  logic             lb_wr,
  input  logic             lb_rd,
  input  logic [31:0]      lb_addr,
  input  logic [31:0]      lb_wr_d,
  output logic [31:0]      lb_rd_d,
  output logic             lb_rd_rdy,
  output logic [LED_W-1:0] led,
  output logic [CNT_W+3:0] events
);

  logic reset_db, pause_db;

  btn_debounce #(.DB_CYC(DB_CYC)) u_db_reset (
    .clk_lb (clk_lb),
    .reset_n(reset_n),
    .din    (btn_reset),
    .dout   (reset_db)
  );

  btn_debounce #(.DB_CYC(DB_CYC)) u_db_pause (
    .clk_lb (clk_lb),
    .reset_n(reset_n),
    .din    (btn_pause),
    .dout   (pause_db)
  );

  logic [NUM_CH-1:0] en_q, dir_q;
  logic [2:0]        led_sel_q;
  logic [CNT_W-1:0]  cnt_v   [NUM_CH];
  ch_state_e         state_v [NUM_CH];
  logic              ovf_v   [NUM_CH];
  logic              hit_cnt [NUM_CH];
  logic [7:0]        offs;
  logic              hit_ctrl, hit_status, wr_status;
  logic              unused_bits;

  // Only the low address byte is decoded, relative to BASE_ADDR.
  assign offs        = lb_addr[7:0] - BASE_ADDR;
  assign hit_ctrl    = (offs == RegCtrl);
  assign hit_status  = (offs == RegStatus);
  assign wr_status   = lb_wr && hit_status;
  assign unused_bits = ^{lb_addr[31:8], lb_wr_d};

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      en_q      <= '1;
      dir_q     <= '0;
      led_sel_q <= '0;
    end else if (lb_wr && hit_ctrl) begin
      en_q      <= lb_wr_d[NUM_CH-1:0];
      dir_q     <= lb_wr_d[8 +: NUM_CH];
      led_sel_q <= lb_wr_d[18:16];
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    ch_state_e        state_q;
    logic             ovf_q;
    logic             clr, load, step, wrap;

    assign hit_cnt[k] = (offs == RegCount0 + 8'(k) * RegStride);
    assign clr        = reset_db || (wr_status && lb_wr_d[8 + k]);
    assign load       = lb_wr && hit_cnt[k];
    // A channel leaving RESET holds its zero for that one edge before counting.
    assign step       = !clr && !load && en_q[k] && !pause_db && (state_q != StReset);
    assign wrap       = step && (dir_q[k] ? (cnt_q == '0) : (&cnt_q));

    always_ff @(posedge clk_lb or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= StReset;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (clr) begin
          state_q <= StReset;
          cnt_q   <= '0;
        end else if (load) begin
          cnt_q <= lb_wr_d[CNT_W-1:0];
        end else if (!en_q[k]) begin
          state_q <= StDisabled;
        end else if (pause_db) begin
          state_q <= StPause;
        end else begin
          state_q <= StCount;
          if (step) cnt_q <= dir_q[k] ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
        end
        if (wrap) ovf_q <= 1'b1;
        else if (wr_status && lb_wr_d[k]) ovf_q <= 1'b0;
      end
    end

    assign cnt_v[k]   = cnt_q;
    assign state_v[k] = state_q;
    assign ovf_v[k]   = ovf_q;
  end

  logic [31:0] rd_val;
  logic        rd_hit;

  always_comb begin
    rd_val = '0;
    rd_hit = 1'b0;
    if (hit_ctrl) begin
      rd_hit              = 1'b1;
      rd_val[NUM_CH-1:0]  = en_q;
      rd_val[8 +: NUM_CH] = dir_q;
      rd_val[18:16]       = led_sel_q;
    end else if (hit_status) begin
      rd_hit        = 1'b1;
      rd_val[25:24] = {pause_db, reset_db};
      for (int k = 0; k < NUM_CH; k++) rd_val[k] = ovf_v[k];
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (hit_cnt[k]) begin
          rd_hit = 1'b1;
          rd_val = 32'(cnt_v[k]);
        end
      end
    end
  end

  logic [31:0] rd_d_q;
  logic        rd_rdy_q;

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) begin
      rd_d_q   <= '0;
      rd_rdy_q <= 1'b0;
    end else begin
      rd_rdy_q <= lb_rd && rd_hit;
      rd_d_q   <= (lb_rd && rd_hit) ? rd_val : '0;
    end
  end

  assign lb_rd_d   = rd_d_q;
  assign lb_rd_rdy = rd_rdy_q;

  logic             sel_ok;
  logic [CNT_W-1:0] sel_cnt;
  ch_state_e        sel_state;

  always_comb begin
    sel_ok    = 1'b0;
    sel_cnt   = '0;
    sel_state = StReset;
    for (int k = 0; k < NUM_CH; k++) begin
      if (led_sel_q == 3'(k)) begin
        sel_ok    = 1'b1;
        sel_cnt   = cnt_v[k];
        sel_state = state_v[k];
      end
    end
  end

  logic [LED_W-1:0] led_q;

  always_ff @(posedge clk_lb or negedge reset_n) begin
    if (!reset_n) led_q <= '0;
    else          led_q <= sel_ok ? sel_cnt[CNT_W-1 -: LED_W] : '0;
  end

  assign led    = led_q;
  assign events = sel_ok ? {sel_state, pause_db, reset_db, sel_cnt} : '0;

endmodule
